omsp_sm_alloc_ctrl: RTL and testbench

//  Next-generation protected-module (SM) controller. It owns an internal table of NB_SM slots (valid, id, text_start, text_end).
//  It serves create/destroy requests over a valid/ready + done handshake, using a multi-cycle scan FSM (one slot per cycle).

---
 rtl/omsp_sm_alloc_ctrl_if.sv | 38 +++
 rtl/omsp_sm_alloc_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_omsp_sm_alloc_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/omsp_sm_alloc_ctrl_if.sv
// ---------------------------------------------------------------------------
// omsp_sm_alloc_ctrl_if
//   Request/response bundle between the SM instruction decoder (master) and
//   the protected-module allocation controller (slave).
//
//   op_valid/op_ready   request handshake, accepted when both are high
//   op_code             00 create, 01 destroy, 1x illegal
//   op_start/op_end     create: text range [op_start, op_end)
//   op_id               destroy: id to remove
//   done                one-cycle completion pulse
//   done_status         0 OK, 1 OVERLAP, 2 FULL, 3 NOT_FOUND,
//                       4 ID_EXHAUSTED, 5 BAD_ARG
//   done_id             id created / destroyed, 0 on failure
// ---------------------------------------------------------------------------
interface omsp_sm_alloc_ctrl_if #(
   parameter int AW   = 16,
   parameter int ID_W = 16
) ();
   logic            op_valid;
   logic            op_ready;
   logic [1:0]      op_code;
   logic [AW-1:0]   op_start;
   logic [AW-1:0]   op_end;
   logic [ID_W-1:0] op_id;
   logic            done;
   logic [2:0]      done_status;
   logic [ID_W-1:0] done_id;

   modport master (
      output op_valid, op_code, op_start, op_end, op_id,
      input  op_ready, done, done_status, done_id
   );

   modport slave (
      input  op_valid, op_code, op_start, op_end, op_id,
      output op_ready, done, done_status, done_id
   );
endinterface

// File: rtl/omsp_sm_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// omsp_sm_alloc_ctrl
//   Protected-module (SM) controller. Keeps a table of NB_SM slots
//   (valid, id, text_start, text_end), serves create/destroy requests with a
//   scan FSM visiting one slot per cycle, resolves the executing SM id from
//   pc every cycle and flags exhaustion of the id space.
//
//   mclk, puc_rst_n   clock / asynchronous active-low reset
//   req               request/response bundle (slave side)
//   pc                current program counter
//   handling_irq      irq entry sequence active
//   irq_num           irq being handled
//   current_id        id of the SM executing now (0 = none)
//   prev_id           id of the last different SM
//   exec_sm           pc lies inside a valid slot
//   enter_sm          current_id changed since last cycle
//   id_exhausted      sticky: id space used up
// ---------------------------------------------------------------------------
module omsp_sm_alloc_ctrl #(
   parameter int NB_SM = 4,
   parameter int AW    = 16,
   parameter int ID_W  = 16,
   parameter int IRQ_W = 4
) (
   input  logic                  mclk,
   input  logic                  puc_rst_n,
   omsp_sm_alloc_ctrl_if.slave   req,
   input  logic [AW-1:0]         pc,
   input  logic                  handling_irq,
   input  logic [IRQ_W-1:0]      irq_num,
   output logic [ID_W-1:0]       current_id,
   output logic [ID_W-1:0]       prev_id,
   output logic                  exec_sm,
   output logic                  enter_sm,
   output logic                  id_exhausted
);

   localparam int              IDX_W    = (NB_SM > 1) ? $clog2(NB_SM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_SM - 1);
   localparam logic [ID_W-1:0] IRQ_BASE = {{(ID_W-IRQ_W){1'b1}}, {IRQ_W{1'b0}}};
   localparam logic [1:0]      OP_CREATE  = 2'b00;
   localparam logic [1:0]      OP_DESTROY = 2'b01;

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_e;

   typedef enum logic [2:0] {
      S_OK           = 3'd0,
      S_OVERLAP      = 3'd1,
      S_FULL         = 3'd2,
      S_NOT_FOUND    = 3'd3,
      S_ID_EXHAUSTED = 3'd4,
      S_BAD_ARG      = 3'd5
   } status_e;

   // Slot table
   logic [NB_SM-1:0] slot_valid_q;
   logic [ID_W-1:0]  slot_id_q    [NB_SM];
   logic [AW-1:0]    slot_start_q [NB_SM];
   logic [AW-1:0]    slot_end_q   [NB_SM];

   // Control / captured request
   state_e          state_q;
   logic [IDX_W-1:0] scan_idx_q;
   logic [1:0]      op_code_q;
   logic [AW-1:0]   op_start_q;
   logic [AW-1:0]   op_end_q;
   logic [ID_W-1:0] op_id_q;
   logic [ID_W-1:0] next_id_q;
   logic            id_exhausted_q;

   // Scan accumulators
   logic            overlap_q, overlap_d;
   logic            free_found_q, free_found_d;
   logic [IDX_W-1:0] free_idx_q, free_idx_d;
   logic            match_found_q, match_found_d;
   logic [IDX_W-1:0] match_idx_q, match_idx_d;

   // Registered response
   logic            done_q;
   status_e         done_status_q;
   logic [ID_W-1:0] done_id_q;

   // pc tracking
   logic [ID_W-1:0] prev_cycle_id_q;
   logic [ID_W-1:0] prev_id_q;

   logic            scan_last;
   status_e         create_status;
   logic            table_wr;
   logic            bad_arg;
   logic            slot_hit;
   logic [ID_W-1:0] hit_id;

   // ------------------------------------------------------------------------
   // Scan datapath: fold the slot at scan_idx_q into the accumulators. The
   // free/match index only latches on the first qualifying slot, giving the
   // lowest index.
   // ------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      overlap_d     = overlap_q | (slot_valid_q[scan_idx_q] &
                                   (op_start_q < slot_end_q[scan_idx_q]) &
                                   (slot_start_q[scan_idx_q] < op_end_q));
      free_found_d  = free_found_q | ~slot_valid_q[scan_idx_q];
      free_idx_d    = free_found_q ? free_idx_q : scan_idx_q;
      match_found_d = match_found_q | (slot_valid_q[scan_idx_q] &
                                       (slot_id_q[scan_idx_q] == op_id_q));
      match_idx_d   = match_found_q ? match_idx_q : scan_idx_q;

      scan_last = (scan_idx_q == LAST_IDX);

      if (overlap_d)                   create_status = S_OVERLAP;
      else if (!free_found_d)          create_status = S_FULL;
      else if (next_id_q == IRQ_BASE)  create_status = S_ID_EXHAUSTED;
      else                             create_status = S_OK;

      table_wr = (state_q == ST_SCAN) && scan_last &&
                 (op_code_q == OP_CREATE) && (create_status == S_OK);

      bad_arg = req.op_code[1] ||
                ((req.op_code == OP_CREATE) && (req.op_end <= req.op_start));
   end

   // ------------------------------------------------------------------------
   // Control FSM, valid bits, id counter and registered outputs
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         state_q         <= ST_IDLE;
         scan_idx_q      <= '0;
         op_code_q       <= '0;
         op_start_q      <= '0;
         op_end_q        <= '0;
         op_id_q         <= '0;
         next_id_q       <= ID_W'(1);
         id_exhausted_q  <= 1'b0;
         slot_valid_q    <= '0;
         overlap_q       <= 1'b0;
         free_found_q    <= 1'b0;
         free_idx_q      <= '0;
         match_found_q   <= 1'b0;
         match_idx_q     <= '0;
         done_q          <= 1'b0;
         done_status_q   <= S_OK;
         done_id_q       <= '0;
         prev_cycle_id_q <= '0;
         prev_id_q       <= '0;
      end else begin
         // Response fields are only non-zero during the done cycle.
         done_q        <= 1'b0;
         done_status_q <= S_OK;
         done_id_q     <= '0;

         prev_cycle_id_q <= current_id;
         if (enter_sm) prev_id_q <= prev_cycle_id_q;

         unique case (state_q)
            ST_IDLE: begin
               if (req.op_valid) begin
                  op_code_q     <= req.op_code;
                  op_start_q    <= req.op_start;
                  op_end_q      <= req.op_end;
                  op_id_q       <= req.op_id;
                  scan_idx_q    <= '0;
                  overlap_q     <= 1'b0;
                  free_found_q  <= 1'b0;
                  free_idx_q    <= '0;
                  match_found_q <= 1'b0;
                  match_idx_q   <= '0;
                  if (bad_arg) begin
                     state_q       <= ST_RESP;
                     done_q        <= 1'b1;
                     done_status_q <= S_BAD_ARG;
                  end else begin
                     state_q <= ST_SCAN;
                  end
               end
            end

            ST_SCAN: begin
               overlap_q     <= overlap_d;
               free_found_q  <= free_found_d;
               free_idx_q    <= free_idx_d;
               match_found_q <= match_found_d;
               match_idx_q   <= match_idx_d;
               scan_idx_q    <= scan_idx_q + IDX_W'(1);
               if (scan_last) begin
                  state_q <= ST_RESP;
                  done_q  <= 1'b1;
                  if (op_code_q == OP_CREATE) begin
                     done_status_q <= create_status;
                     if (create_status == S_OK) begin
                        slot_valid_q[free_idx_d] <= 1'b1;
                        done_id_q                <= next_id_q;
                        next_id_q                <= next_id_q + ID_W'(1);
                     end
                     if (create_status == S_ID_EXHAUSTED) id_exhausted_q <= 1'b1;
                  end else if (match_found_d) begin
                     slot_valid_q[match_idx_d] <= 1'b0;
                     done_status_q             <= S_OK;
                     done_id_q                 <= op_id_q;
                  end else begin
                     done_status_q <= S_NOT_FOUND;
                  end
               end
            end

            ST_RESP: state_q <= ST_IDLE;

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Slot payload. Qualified everywhere by slot_valid_q, so it carries no reset.
   // ------------------------------------------------------------------------
   // NOTE: table storage is deliberately not reset; only the valid bits are.
   always_ff @(posedge mclk) begin
      if (table_wr) begin
         slot_id_q[free_idx_d]    <= next_id_q;
         slot_start_q[free_idx_d] <= op_start_q;
         slot_end_q[free_idx_d]   <= op_end_q;
      end
   end

   // ------------------------------------------------------------------------
   // pc lookup: descending loop so the lowest-index hit wins.
   // ------------------------------------------------------------------------
   always_comb begin
      slot_hit = 1'b0;
      hit_id   = '0;
      for (int i = NB_SM - 1; i >= 0; i--) begin
         if (slot_valid_q[i] && (pc >= slot_start_q[i]) && (pc < slot_end_q[i])) begin
            slot_hit = 1'b1;
            hit_id   = slot_id_q[i];
         end
      end

      if (handling_irq)  current_id = IRQ_BASE + ID_W'(irq_num);
      else if (slot_hit) current_id = hit_id;
      else               current_id = '0;
   end

   assign exec_sm          = slot_hit;
   assign enter_sm         = (prev_cycle_id_q != current_id);
   assign prev_id          = prev_id_q;
   assign id_exhausted     = id_exhausted_q;
   assign req.op_ready     = (state_q == ST_IDLE);
   assign req.done         = done_q;
   assign req.done_status  = done_status_q;
   assign req.done_id      = done_id_q;

endmodule

// File: tb/tb_omsp_sm_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_omsp_sm_alloc_ctrl
//   Directed bench for omsp_sm_alloc_ctrl. dut_a uses default parameters;
//   dut_b uses ID_W=8 so the id space can be exhausted in few cycles.
// ---------------------------------------------------------------------------
module tb_omsp_sm_alloc_ctrl;

   localparam logic [2:0] S_OK = 3'd0, S_OVERLAP = 3'd1, S_FULL = 3'd2,
                          S_NOT_FOUND = 3'd3, S_ID_EXH = 3'd4, S_BAD_ARG = 3'd5;
   localparam logic [1:0] OP_CREATE = 2'b00, OP_DESTROY = 2'b01;

   logic mclk;
   logic puc_rst_n;

   int checks   = 0;
   int failures = 0;

   // dut_a side signals
   logic [15:0] pc_a;
   logic        hirq_a;
   logic [3:0]  irqn_a;
   logic [15:0] cur_a, prev_a;
   logic        exec_a, enter_a, exh_a;

   // dut_b side signals
   logic [15:0] pc_b;
   logic        hirq_b;
   logic [3:0]  irqn_b;
   logic [7:0]  cur_b, prev_b;
   logic        exec_b, enter_b, exh_b;

   omsp_sm_alloc_ctrl_if #(.AW(16), .ID_W(16)) ifa ();
   omsp_sm_alloc_ctrl_if #(.AW(16), .ID_W(8))  ifb ();

   omsp_sm_alloc_ctrl #(.NB_SM(4), .AW(16), .ID_W(16), .IRQ_W(4)) dut_a (
      .mclk         (mclk),
      .puc_rst_n    (puc_rst_n),
      .req          (ifa),
      .pc           (pc_a),
      .handling_irq (hirq_a),
      .irq_num      (irqn_a),
      .current_id   (cur_a),
      .prev_id      (prev_a),
      .exec_sm      (exec_a),
      .enter_sm     (enter_a),
      .id_exhausted (exh_a)
   );

   omsp_sm_alloc_ctrl #(.NB_SM(4), .AW(16), .ID_W(8), .IRQ_W(4)) dut_b (
      .mclk         (mclk),
      .puc_rst_n    (puc_rst_n),
      .req          (ifb),
      .pc           (pc_b),
      .handling_irq (hirq_b),
      .irq_num      (irqn_b),
      .current_id   (cur_b),
      .prev_id      (prev_b),
      .exec_sm      (exec_b),
      .enter_sm     (enter_b),
      .id_exhausted (exh_b)
   );

   always #5 mclk = ~mclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request and wait (bounded) for its done pulse. lat counts the
   // cycle in which done is seen, 1 being the cycle right after accept.
   // post_idle reports that the cycle after done is back to idle with zeroed
   // response fields.
   task automatic run_op(input bit use_b, input logic [1:0] code,
                         input logic [15:0] s, input logic [15:0] e,
                         input logic [15:0] id,
                         output logic [2:0] st, output logic [15:0] did,
                         output int lat, output logic [15:0] cur_d,
                         output logic ent_d, output logic post_idle);
      int w = 0;
      while (!(use_b ? ifb.op_ready : ifa.op_ready) && w < 20) begin
         @(negedge mclk);
         w++;
      end
      if (use_b) begin
         ifb.op_valid = 1'b1; ifb.op_code = code; ifb.op_start = s;
         ifb.op_end = e; ifb.op_id = id[7:0];
      end else begin
         ifa.op_valid = 1'b1; ifa.op_code = code; ifa.op_start = s;
         ifa.op_end = e; ifa.op_id = id;
      end
      @(posedge mclk);
      @(negedge mclk);
      // Garbage on op_* while busy must be ignored.
      ifa.op_valid = 1'b0; ifa.op_code = 2'b11; ifa.op_start = 16'h1234;
      ifa.op_end = 16'h0001; ifa.op_id = 16'hFFFF;
      ifb.op_valid = 1'b0; ifb.op_code = 2'b11; ifb.op_start = 16'h1234;
      ifb.op_end = 16'h0001; ifb.op_id = 8'hFF;
      lat = 1;
      while (!(use_b ? ifb.done : ifa.done) && lat < 20) begin
         @(negedge mclk);
         lat++;
      end
      st    = use_b ? ifb.done_status : ifa.done_status;
      did   = use_b ? {8'h00, ifb.done_id} : ifa.done_id;
      cur_d = cur_a;
      ent_d = enter_a;
      @(negedge mclk);
      if (use_b) post_idle = ifb.op_ready && !ifb.done && ifb.done_status == 3'd0 && ifb.done_id == 8'h00;
      else       post_idle = ifa.op_ready && !ifa.done && ifa.done_status == 3'd0 && ifa.done_id == 16'h0000;
   endtask

   logic [2:0]  r_st;
   logic [15:0] r_id, r_cur;
   int          r_lat;
   logic        r_ent, r_post;

   task automatic test_reset;
      puc_rst_n = 1'b0;
      repeat (3) @(negedge mclk);
      puc_rst_n = 1'b1;
      @(negedge mclk);
      checks++; if (ifa.op_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ifa.op_ready); end
      checks++; if ({ifa.done, ifa.done_status, ifa.done_id} !== 20'h0) begin failures++; $display("FAIL reset_done: got %b/%0d/%0h expected 0/0/0", ifa.done, ifa.done_status, ifa.done_id); end
      checks++; if ({cur_a, prev_a, exec_a, enter_a, exh_a} !== 35'h0) begin failures++; $display("FAIL reset_ids: got cur=%0h prev=%0h exec=%b enter=%b exh=%b expected all 0", cur_a, prev_a, exec_a, enter_a, exh_a); end
   endtask

   task automatic test_create_overlap;
      run_op(0, OP_CREATE, 16'h8000, 16'h8100, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_lat !== 5) begin failures++; $display("FAIL create1_latency: got %0d expected 5", r_lat); end
      checks++; if (r_st !== S_OK || r_id !== 16'd1) begin failures++; $display("FAIL create1_result: got status %0d id %0h expected 0 id 1", r_st, r_id); end
      checks++; if (r_post !== 1'b1) begin failures++; $display("FAIL create1_single_pulse: got %b expected 1", r_post); end
      run_op(0, OP_CREATE, 16'h80F0, 16'h8200, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OVERLAP || r_id !== 16'd0) begin failures++; $display("FAIL overlap_result: got status %0d id %0h expected 1 id 0", r_st, r_id); end
      run_op(0, OP_CREATE, 16'h8100, 16'h8200, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OK || r_id !== 16'd2) begin failures++; $display("FAIL adjacent_create: got status %0d id %0h expected 0 id 2", r_st, r_id); end
   endtask

   task automatic test_lookup;
      pc_a = 16'h7FFE;
      @(negedge mclk);
      @(negedge mclk);
      checks++; if (cur_a !== 16'h0 || exec_a !== 1'b0 || enter_a !== 1'b0) begin failures++; $display("FAIL lookup_outside: got cur=%0h exec=%b enter=%b expected 0/0/0", cur_a, exec_a, enter_a); end
      pc_a = 16'h8000;
      #1;
      checks++; if (cur_a !== 16'd1 || exec_a !== 1'b1 || enter_a !== 1'b1 || prev_a !== 16'h0) begin failures++; $display("FAIL lookup_enter: got cur=%0h exec=%b enter=%b prev=%0h expected 1/1/1/0", cur_a, exec_a, enter_a, prev_a); end
      @(negedge mclk);
      checks++; if (cur_a !== 16'd1 || enter_a !== 1'b0 || prev_a !== 16'h0) begin failures++; $display("FAIL lookup_settle: got cur=%0h enter=%b prev=%0h expected 1/0/0", cur_a, enter_a, prev_a); end
      hirq_a = 1'b1; irqn_a = 4'd5;
      #1;
      checks++; if (cur_a !== 16'hFFF5 || enter_a !== 1'b1) begin failures++; $display("FAIL irq_id: got cur=%0h enter=%b expected fff5/1", cur_a, enter_a); end
      @(negedge mclk);
      checks++; if (prev_a !== 16'd1 || enter_a !== 1'b0) begin failures++; $display("FAIL irq_prev: got prev=%0h enter=%b expected 1/0", prev_a, enter_a); end
      hirq_a = 1'b0; irqn_a = 4'd0; pc_a = 16'h0000;
      @(negedge mclk);
      @(negedge mclk);
   endtask

   task automatic test_full;
      run_op(0, OP_CREATE, 16'h9000, 16'h9100, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OK || r_id !== 16'd3) begin failures++; $display("FAIL fill3: got status %0d id %0h expected 0 id 3", r_st, r_id); end
      run_op(0, OP_CREATE, 16'h9100, 16'h9200, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OK || r_id !== 16'd4) begin failures++; $display("FAIL fill4: got status %0d id %0h expected 0 id 4", r_st, r_id); end
      run_op(0, OP_CREATE, 16'hA000, 16'hA100, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_FULL || r_id !== 16'd0) begin failures++; $display("FAIL full: got status %0d id %0h expected 2 id 0", r_st, r_id); end
      run_op(0, OP_DESTROY, 16'h0, 16'h0, 16'd3, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OK || r_id !== 16'd3 || r_lat !== 5) begin failures++; $display("FAIL destroy3: got status %0d id %0h lat %0d expected 0 id 3 lat 5", r_st, r_id, r_lat); end
      run_op(0, OP_DESTROY, 16'h0, 16'h0, 16'd3, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_NOT_FOUND || r_id !== 16'd0) begin failures++; $display("FAIL destroy3_again: got status %0d id %0h expected 3 id 0", r_st, r_id); end
      run_op(0, OP_CREATE, 16'hA000, 16'hA100, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OK || r_id !== 16'd5) begin failures++; $display("FAIL refill: got status %0d id %0h expected 0 id 5", r_st, r_id); end
      pc_a = 16'hA050;
      @(negedge mclk);
      checks++; if (cur_a !== 16'd5 || exec_a !== 1'b1) begin failures++; $display("FAIL lookup_new_slot: got cur=%0h exec=%b expected 5/1", cur_a, exec_a); end
      run_op(0, OP_DESTROY, 16'h0, 16'h0, 16'd5, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OK || r_cur !== 16'h0 || r_ent !== 1'b1) begin failures++; $display("FAIL destroy_executing: got status %0d cur %0h enter %b expected 0/0/1", r_st, r_cur, r_ent); end
      pc_a = 16'h0000;
      @(negedge mclk);
   endtask

   task automatic test_bad_arg;
      run_op(0, 2'b10, 16'h8000, 16'h9000, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_BAD_ARG || r_id !== 16'd0 || r_lat !== 1) begin failures++; $display("FAIL illegal_op: got status %0d id %0h lat %0d expected 5 id 0 lat 1", r_st, r_id, r_lat); end
      checks++; if (r_post !== 1'b1) begin failures++; $display("FAIL illegal_op_pulse: got %b expected 1", r_post); end
      run_op(0, OP_CREATE, 16'hB000, 16'hB000, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_BAD_ARG || r_lat !== 1) begin failures++; $display("FAIL empty_range: got status %0d lat %0d expected 5 lat 1", r_st, r_lat); end
      run_op(0, OP_CREATE, 16'hB000, 16'hB100, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OK || r_id !== 16'd6) begin failures++; $display("FAIL id_after_bad_arg: got status %0d id %0h expected 0 id 6", r_st, r_id); end
   endtask

   task automatic test_id_exhaust;
      int bad = 0;
      for (int i = 1; i <= 239; i++) begin
         run_op(1, OP_CREATE, 16'h0100, 16'h0200, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
         checks++; if (r_st !== S_OK || r_id !== 16'(i)) begin failures++; bad++; if (bad < 5) $display("FAIL exh_create_%0d: got status %0d id %0h expected 0 id %0h", i, r_st, r_id, i); end
         run_op(1, OP_DESTROY, 16'h0, 16'h0, 16'(i), r_st, r_id, r_lat, r_cur, r_ent, r_post);
         checks++; if (r_st !== S_OK || r_id !== 16'(i)) begin failures++; bad++; if (bad < 5) $display("FAIL exh_destroy_%0d: got status %0d id %0h expected 0 id %0h", i, r_st, r_id, i); end
      end
      checks++; if (exh_b !== 1'b0) begin failures++; $display("FAIL exh_flag_early: got %b expected 0", exh_b); end
      run_op(1, OP_CREATE, 16'h0100, 16'h0200, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_ID_EXH || r_id !== 16'd0) begin failures++; $display("FAIL exhausted: got status %0d id %0h expected 4 id 0", r_st, r_id); end
      checks++; if (exh_b !== 1'b1) begin failures++; $display("FAIL exh_flag_set: got %b expected 1", exh_b); end
      repeat (3) @(negedge mclk);
      checks++; if (exh_b !== 1'b1) begin failures++; $display("FAIL exh_flag_sticky: got %b expected 1", exh_b); end
   endtask

   task automatic test_reset_mid_scan;
      int seen_done = 0;
      ifa.op_valid = 1'b1; ifa.op_code = OP_CREATE;
      ifa.op_start = 16'hC000; ifa.op_end = 16'hC100; ifa.op_id = 16'h0;
      @(posedge mclk);
      @(negedge mclk);
      ifa.op_valid = 1'b0;
      @(negedge mclk);
      puc_rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1; if (ifa.done) seen_done++;
         @(negedge mclk);
      end
      puc_rst_n = 1'b1;
      pc_a = 16'h8000;
      for (int i = 0; i < 6; i++) begin
         @(negedge mclk); if (ifa.done) seen_done++;
      end
      checks++; if (seen_done !== 0) begin failures++; $display("FAIL abort_no_done: got %0d done cycles expected 0", seen_done); end
      checks++; if (ifa.op_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", ifa.op_ready); end
      checks++; if (cur_a !== 16'h0 || exec_a !== 1'b0) begin failures++; $display("FAIL abort_table_empty: got cur=%0h exec=%b expected 0/0", cur_a, exec_a); end
      checks++; if (exh_b !== 1'b0) begin failures++; $display("FAIL exh_cleared_by_reset: got %b expected 0", exh_b); end
      run_op(0, OP_CREATE, 16'h8000, 16'h8100, 16'h0, r_st, r_id, r_lat, r_cur, r_ent, r_post);
      checks++; if (r_st !== S_OK || r_id !== 16'd1 || r_lat !== 5) begin failures++; $display("FAIL post_reset_create: got status %0d id %0h lat %0d expected 0 id 1 lat 5", r_st, r_id, r_lat); end
   endtask

   initial begin
      mclk = 1'b0;
      puc_rst_n = 1'b0;
      pc_a = 16'h0; hirq_a = 1'b0; irqn_a = 4'd0;
      pc_b = 16'h0; hirq_b = 1'b0; irqn_b = 4'd0;
      ifa.op_valid = 1'b0; ifa.op_code = 2'b00; ifa.op_start = '0; ifa.op_end = '0; ifa.op_id = '0;
      ifb.op_valid = 1'b0; ifb.op_code = 2'b00; ifb.op_start = '0; ifb.op_end = '0; ifb.op_id = '0;

      test_reset();
      test_create_overlap();
      test_lookup();
      test_full();
      test_bad_arg();
      test_id_exhaust();
      test_reset_mid_scan();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
